b_decoder_nt2n_pipe: RTL and testbench
======================================

// Module: b_decoder_nt2n_pipe
// PURPOSE
//  Parametrised registered binary decoder: IN_W-bit index -> OUT_W-bit one-hot or thermometer code.
//  Valid/ready on both sides, with a 2-entry (main + skid) output buffer for full throughput under backpressure.
//  Flags out-of-range indices and counts completed output transfers.
//  Generalised, pipelined successor of the combinational 2-to-4 decoder; sits between control FSMs and select/enable fan-out.
// PARAMETERS
//  IN_W     2          index width, >=1
//  OUT_W    2**IN_W    output code width, 2..2**IN_W
//  MODE     0          0 = one-hot, 1 = thermometer
//  ACT_LOW  0          1 = invert final data_out, idle code included
//  CNT_W    8          width of dec_count
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-high
//  in_valid  in   1       datain/in_en valid
//  in_ready  out  1       block can accept this cycle
//  datain    in   IN_W    index to decode
//  in_en     in   1       0 = emit idle code for this transfer
//  out_valid out  1       data_out/out_err valid
//  out_ready in   1       downstream accepts
//  data_out  out  OUT_W   decoded code
//  out_err   out  1       transfer had datain >= OUT_W
//  dec_count out  CNT_W   completed output handshakes, mod 2**CNT_W
// BEHAVIOUR
//  Reset values:
//   - rst asserted (async, takes effect immediately): mv=0, sv=0, out_valid=0, out_err=0, dec_count=0.
//   - data_out = idle code: all-0 (ACT_LOW=0) or all-1 (ACT_LOW=1).
//   - in_ready=0 while rst is high.
//  Handshake definitions:
//   - in_ready = ~sv & ~rst.
//   - accept   = in_valid & in_ready.
//   - take     = out_valid & out_ready.
//   - out_valid = mv; data_out/out_err driven from main register M.
//  Code generation (idx = datain):
//   - in_en=0 -> idle code, err=0.
//   - idx>=OUT_W -> idle code, err=1.
//   - MODE0: bit k=1 iff k==idx.
//   - MODE1: bit k=1 iff k<=idx.
//   - ACT_LOW applied last.
//  Update at posedge clk:
//   - If ~mv | out_ready (M free or draining):
//       - If sv: M<=S, sv<=0. Any accept here is impossible, since in_ready=0.
//       - Else if accept: M<=new, mv<=1.
//       - Else: mv<=0, M data holds.
//   - Else (stalled): if accept, S<=new and sv<=1.
//   - Invariant: sv=1 implies mv=1.
//  Latency and throughput:
//   - 1 cycle from accept to out_valid.
//   - 1 transfer/cycle with out_ready held high.
//   - At most 2 items in flight.
//  Output stability: while out_valid & ~out_ready, data_out/out_err are stable.
//  Empty state: when mv=0, data_out holds its last value and downstream must ignore it.
//  Simultaneous take + accept with sv=0: new item replaces M in the same edge, with no bubble.
//  dec_count: +1 per take; wraps 2**CNT_W-1 -> 0.
//  Reset mid-stall: both entries discarded, no partial transfer, count cleared.
// TESTING
//  1. Reset: rst=1 -> out_valid=0, in_ready=0, data_out=0000, dec_count=0; rst=0 -> in_ready=1 next cycle.
//  2. Default params, out_ready=1, datain 0,1,2,3 back-to-back -> data_out 0001,0010,0100,1000 on consecutive cycles after 1-cycle latency; dec_count=4.
//  3. Backpressure, out_ready=0:
//     - Send 2 then 3 -> data_out=0100 held, in_ready=0, third item not accepted.
//     - out_ready=1 -> 0100 then 1000, then in_ready=1.
//  4. IN_W=3, OUT_W=6, MODE=1: datain 3 -> 001111/err0; datain 6 -> 000000/err1; datain 5 -> 111111.
//  5. ACT_LOW=1: reset -> 1111; datain 1 -> 1101; in_en=0 with datain 2 -> 1111/err0.
//  6. Pulse rst between edges during stall with 2 items buffered -> out_valid drops immediately, dec_count=0, no stale item after release. CNT_W=2 with 5 takes -> dec_count=1.

Source files
------------

// File: rtl/b_decoder_nt2n_pipe_if.sv
// Valid/ready bus for the pipelined decoder: index request side plus decoded-code response side.
interface b_decoder_nt2n_pipe_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2 ** IN_W,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  datain;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] data_out;
    logic             out_err;
    logic [CNT_W-1:0] dec_count;

    modport master (
        output in_valid, datain, in_en, out_ready,
        input  in_ready, out_valid, data_out, out_err, dec_count
    );

    modport slave (
        input  in_valid, datain, in_en, out_ready,
        output in_ready, out_valid, data_out, out_err, dec_count
    );
endinterface

// File: rtl/b_decoder_nt2n_pipe.sv
// Registered IN_W -> OUT_W one-hot/thermometer decoder with a main+skid output buffer,
// out-of-range flagging and a count of completed output transfers.
module b_decoder_nt2n_pipe #(
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2 ** IN_W,
    parameter int MODE    = 0,
    parameter int ACT_LOW = 0,
    parameter int CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    b_decoder_nt2n_pipe_if.slave bus
);
    localparam int XW = IN_W + 1;
    localparam logic [OUT_W-1:0] IDLE = (ACT_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [XW-1:0]    idx;
    logic [OUT_W-1:0] new_code;
    logic             new_err;
    logic [OUT_W-1:0] m_code;
    logic             m_err;
    logic             mv;
    logic [OUT_W-1:0] s_code;
    logic             s_err;
    logic             sv;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             take;

    // Extra zero bit lets the index be compared against OUT_W, which may equal 2**IN_W.
    assign idx = {1'b0, bus.datain};

    // Disabled and out-of-range requests both decode to the idle code; polarity is applied last.
    always_comb begin
        new_code = '0;
        new_err  = 1'b0;
        if (bus.in_en) begin
            if (idx >= XW'(OUT_W)) begin
                new_err = 1'b1;
            end else begin
                for (int k = 0; k < OUT_W; k++) begin
                    new_code[k] = (MODE == 1) ? (XW'(k) <= idx) : (XW'(k) == idx);
                end
            end
        end
        new_code = new_code ^ IDLE;
    end

    assign bus.in_ready  = ~sv & ~rst;
    assign accept        = bus.in_valid & bus.in_ready;
    assign take          = mv & bus.out_ready;
    assign bus.out_valid = mv;
    assign bus.data_out  = m_code;
    assign bus.out_err   = m_err;
    assign bus.dec_count = count;

    // The skid entry only fills while the main entry is stalled, and drains back into it
    // before any new request is admitted, so ordering is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv     <= 1'b0;
            sv     <= 1'b0;
            m_code <= IDLE;
            m_err  <= 1'b0;
            s_code <= IDLE;
            s_err  <= 1'b0;
            count  <= '0;
        end else begin
            if (take) begin
                count <= count + CNT_W'(1);
            end
            if (~mv | bus.out_ready) begin
                if (sv) begin
                    m_code <= s_code;
                    m_err  <= s_err;
                    sv     <= 1'b0;
                end else if (accept) begin
                    m_code <= new_code;
                    m_err  <= new_err;
                    mv     <= 1'b1;
                end else begin
                    mv <= 1'b0;
                end
            end else if (accept) begin
                s_code <= new_code;
                s_err  <= new_err;
                sv     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_b_decoder_nt2n_pipe.sv
// Bench for b_decoder_nt2n_pipe: three parameterisations checked against a 2-deep FIFO model
// every cycle, plus hand-computed directed expectations.
module tb_b_decoder_nt2n_pipe;
    typedef struct {
        int code;
        bit err;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    int    outw_t[3]  = '{4, 6, 4};
    int    mode_t[3]  = '{0, 1, 0};
    int    actl_t[3]  = '{0, 0, 1};
    int    cmod_t[3]  = '{256, 256, 4};
    string name_t[3]  = '{"a", "b", "c"};
    item_t mq[3][$];
    int    mcnt[3]    = '{0, 0, 0};

    always #5 clk = ~clk;

    b_decoder_nt2n_pipe_if #(.IN_W(2), .OUT_W(4), .CNT_W(8)) ba ();
    b_decoder_nt2n_pipe_if #(.IN_W(3), .OUT_W(6), .CNT_W(8)) bb ();
    b_decoder_nt2n_pipe_if #(.IN_W(2), .OUT_W(4), .CNT_W(2)) bc ();

    b_decoder_nt2n_pipe #(.IN_W(2), .OUT_W(4), .MODE(0), .ACT_LOW(0), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ba));
    b_decoder_nt2n_pipe #(.IN_W(3), .OUT_W(6), .MODE(1), .ACT_LOW(0), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(bb));
    b_decoder_nt2n_pipe #(.IN_W(2), .OUT_W(4), .MODE(0), .ACT_LOW(1), .CNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(bc));

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Expected code from plain arithmetic: one-hot is a shift, thermometer is a shifted mask.
    function automatic item_t modelCode(input int id, input int idx, input bit en);
        item_t it;
        int    c    = 0;
        int    mask = (1 << outw_t[id]) - 1;
        it.err = en && (idx >= outw_t[id]);
        if (en && !it.err) c = (mode_t[id] == 1) ? ((2 << idx) - 1) : (1 << idx);
        if (actl_t[id] == 1) c = ~c & mask;
        it.code = c;
        return it;
    endfunction

    task automatic modelCycle(input int id, input logic [31:0] vld, input logic [31:0] rdy,
                              input logic [31:0] dat, input logic [31:0] err,
                              input logic [31:0] cnt, input logic in_valid, input int datain,
                              input logic in_en, input logic out_ready);
        string nm = name_t[id];
        bit    acc;
        bit    tk;
        if (rst) begin
            mq[id].delete();
            mcnt[id] = 0;
            checkOutput({nm, "_rst_valid"}, vld, 0);
            checkOutput({nm, "_rst_ready"}, rdy, 0);
            checkOutput({nm, "_rst_count"}, cnt, 0);
            checkOutput({nm, "_rst_data"}, dat, (actl_t[id] == 1) ? ((1 << outw_t[id]) - 1) : 0);
        end else begin
            checkOutput({nm, "_valid"}, vld, 32'(mq[id].size() != 0));
            checkOutput({nm, "_ready"}, rdy, 32'(mq[id].size() < 2));
            checkOutput({nm, "_count"}, cnt, 32'(mcnt[id] % cmod_t[id]));
            if (mq[id].size() != 0) begin
                checkOutput({nm, "_data"}, dat, 32'(mq[id][0].code));
                checkOutput({nm, "_err"}, err, 32'(mq[id][0].err));
            end
            tk  = (mq[id].size() != 0) && out_ready;
            acc = in_valid && (mq[id].size() < 2);
            if (tk) begin
                void'(mq[id].pop_front());
                mcnt[id]++;
            end
            if (acc) mq[id].push_back(modelCode(id, datain, in_en));
        end
    endtask

    // Inputs change just after posedge, so values seen here hold through the next edge.
    always @(negedge clk) begin
        modelCycle(0, 32'(ba.out_valid), 32'(ba.in_ready), 32'(ba.data_out), 32'(ba.out_err),
                   32'(ba.dec_count), ba.in_valid, int'(ba.datain), ba.in_en, ba.out_ready);
        modelCycle(1, 32'(bb.out_valid), 32'(bb.in_ready), 32'(bb.data_out), 32'(bb.out_err),
                   32'(bb.dec_count), bb.in_valid, int'(bb.datain), bb.in_en, bb.out_ready);
        modelCycle(2, 32'(bc.out_valid), 32'(bc.in_ready), 32'(bc.data_out), 32'(bc.out_err),
                   32'(bc.dec_count), bc.in_valid, int'(bc.datain), bc.in_en, bc.out_ready);
    end

    always @(posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
    end

    task automatic applyStimulus(input int id, input bit vld, input int idx, input bit en,
                                 input bit ordy);
        @(posedge clk);
        #1;
        case (id)
            0: begin
                ba.in_valid = vld; ba.datain = idx[1:0]; ba.in_en = en; ba.out_ready = ordy;
            end
            1: begin
                bb.in_valid = vld; bb.datain = idx[2:0]; bb.in_en = en; bb.out_ready = ordy;
            end
            default: begin
                bc.in_valid = vld; bc.datain = idx[1:0]; bc.in_en = en; bc.out_ready = ordy;
            end
        endcase
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ba.in_valid = 0; ba.datain = '0; ba.in_en = 1; ba.out_ready = 1;
        bb.in_valid = 0; bb.datain = '0; bb.in_en = 1; bb.out_ready = 1;
        bc.in_valid = 0; bc.datain = '0; bc.in_en = 1; bc.out_ready = 1;

        // Reset state, including the inverted idle code
        repeat (2) @(negedge clk);
        checkOutput("t1_valid", 32'(ba.out_valid), 0);
        checkOutput("t1_ready", 32'(ba.in_ready), 0);
        checkOutput("t1_data", 32'(ba.data_out), 32'h0);
        checkOutput("t1_count", 32'(ba.dec_count), 0);
        checkOutput("t5_rst_data", 32'(bc.data_out), 32'hf);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_ready_release", 32'(ba.in_ready), 1);

        // Back-to-back one-hot stream
        applyStimulus(0, 1, 0, 1, 1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, i < 4, i, 1, 1);
            @(negedge clk);
            checkOutput($sformatf("t2_data%0d", i - 1), 32'(ba.data_out), 32'(1 << (i - 1)));
        end
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t2_count", 32'(ba.dec_count), 4);

        // Backpressure fills main and skid, third request refused
        applyStimulus(0, 1, 2, 1, 0);
        applyStimulus(0, 1, 3, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        @(negedge clk);
        checkOutput("t3_held", 32'(ba.data_out), 32'b0100);
        checkOutput("t3_ready0", 32'(ba.in_ready), 0);
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t3_first", 32'(ba.data_out), 32'b0100);
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t3_second", 32'(ba.data_out), 32'b1000);
        checkOutput("t3_ready1", 32'(ba.in_ready), 1);
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t3_drained", 32'(ba.out_valid), 0);

        // Thermometer with OUT_W below 2**IN_W
        applyStimulus(1, 1, 3, 1, 1);
        applyStimulus(1, 1, 6, 1, 1);
        @(negedge clk);
        checkOutput("t4_d3", 32'(bb.data_out), 32'b001111);
        checkOutput("t4_e3", 32'(bb.out_err), 0);
        applyStimulus(1, 1, 5, 1, 1);
        @(negedge clk);
        checkOutput("t4_d6", 32'(bb.data_out), 32'b000000);
        checkOutput("t4_e6", 32'(bb.out_err), 1);
        applyStimulus(1, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t4_d5", 32'(bb.data_out), 32'b111111);

        // Active-low output and idle code for disabled requests
        applyStimulus(2, 1, 1, 1, 1);
        applyStimulus(2, 1, 2, 0, 1);
        @(negedge clk);
        checkOutput("t5_d1", 32'(bc.data_out), 32'b1101);
        applyStimulus(2, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t5_idle", 32'(bc.data_out), 32'b1111);
        checkOutput("t5_err", 32'(bc.out_err), 0);

        // Reset pulse between edges while both entries are full
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("t6_full", 32'(ba.in_ready), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_valid_drop", 32'(ba.out_valid), 0);
        checkOutput("t6_count_clr", 32'(ba.dec_count), 0);
        #1 rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t6_no_stale", 32'(ba.out_valid), 0);

        // Count wrap at CNT_W=2
        for (int i = 0; i < 5; i++) applyStimulus(2, 1, i % 4, 1, 1);
        applyStimulus(2, 0, 0, 1, 1);
        applyStimulus(2, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t6_wrap", 32'(bc.dec_count), 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
